// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the CPU memory stage and a
//   DMA/debug master. One grant per cycle at most. Ties are broken by
//   round-robin on the last granted port. A DMA locked burst is capped at
//   MAX_BURST beats so the CPU cannot starve.
//   Memory reads are combinational and writes happen on the clock edge, so a
//   grant is a 0-cycle handshake: the winner's access completes in its grant
//   cycle.
//
// Ports
//   clk, reset              clock (rising edge), async active-high reset
//   cpu_req/we/addr/wdata   CPU access request
//   cpu_rdata, cpu_gnt      CPU load data and grant
//   cpu_stall               cpu_req & ~cpu_gnt, sent to the hazard unit
//   dma_req/we/addr/wdata   DMA access request
//   dma_lock                DMA requests a locked burst
//   dma_gnt, dma_rdata      DMA grant and read data
//   mem_we/a/wd, mem_rd     data memory interface
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t           st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;   // 0 = CPU, 1 = DMA

    logic             locked_beat;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= ST_IDLE;
            cnt_q  <= '0;
            last_q <= 1'b1;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;

        // A held lock gives the DMA absolute priority. Once the lock or the
        // request drops, this same cycle is arbitrated exactly as in IDLE.
        locked_beat = (st_q == ST_LOCK) && dma_req && dma_lock;

        if (locked_beat) begin
            dma_gnt = 1'b1;
        end else if (cpu_req && dma_req) begin
            if (last_q) begin
                cpu_gnt = 1'b1;
            end else begin
                dma_gnt = 1'b1;
            end
        end else if (cpu_req) begin
            cpu_gnt = 1'b1;
        end else if (dma_req) begin
            dma_gnt = 1'b1;
        end

        // Reset suppresses every access, including an in-flight burst write.
        if (reset) begin
            cpu_gnt = 1'b0;
            dma_gnt = 1'b0;
        end

        if ((st_q == ST_LOCK) && !locked_beat) begin
            st_d  = ST_IDLE;
            cnt_d = '0;
        end

        if (dma_gnt) begin
            last_d = 1'b1;
            if (locked_beat) begin
                if (cnt_inc == CNT_W'(MAX_BURST)) begin
                    st_d  = ST_IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end else if (dma_lock && (MAX_BURST > 1)) begin
                st_d  = ST_LOCK;
                cnt_d = CNT_W'(1);
            end
        end else if (cpu_gnt) begin
            last_d = 1'b0;
        end
    end

    always_comb begin
        if (dma_gnt) begin
            mem_a  = dma_addr;
            mem_wd = dma_wdata;
        end else begin
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
        end
    end

    assign mem_we    = (cpu_gnt & cpu_we) | (dma_gnt & dma_we);
    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign cpu_rdata = mem_rd;
    assign dma_rdata = mem_rd;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
    logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic [31:0] cpu_rdata, dma_rdata, mem_a, mem_wd, mem_rd;
    logic        cpu_gnt, cpu_stall, dma_gnt, mem_we;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_BURST(4), .CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .cpu_gnt  (cpu_gnt),
        .cpu_stall(cpu_stall),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_lock (dma_lock),
        .dma_gnt  (dma_gnt),
        .dma_rdata(dma_rdata),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd)
    );

    // Single-port memory: combinational read, write on the rising edge.
    assign mem_rd = (mem_a[31:10] == '0 && mem_a[1:0] == 2'b00) ? mem[mem_a[9:2]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (mem_we) mem[mem_a[9:2]] <= mem_wd;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic check_grant(input string tag, input logic exp_cpu, input logic exp_dma);
        check({tag, " cpu_gnt"}, {31'd0, cpu_gnt}, {31'd0, exp_cpu});
        check({tag, " dma_gnt"}, {31'd0, dma_gnt}, {31'd0, exp_dma});
        check({tag, " cpu_stall"}, {31'd0, cpu_stall}, {31'd0, cpu_req & ~exp_cpu});
    endtask

    logic [8:0] burst_pat;
    logic [7:0] drop_pat;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0; dma_lock = 1'b0;

        // Reset held with the CPU requesting
        next_cycle(); #1;
        check("rst cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
        check("rst dma_gnt", {31'd0, dma_gnt}, 32'd0);
        check("rst cpu_stall", {31'd0, cpu_stall}, 32'd1);
        check("rst mem_we", {31'd0, mem_we}, 32'd0);

        // Release: CPU granted in the same cycle
        next_cycle(); reset = 1'b0; #1;
        check_grant("rel", 1'b1, 1'b0);

        // DMA-only cycle leaves last = DMA
        next_cycle(); cpu_req = 1'b0; dma_req = 1'b1; #1;
        check_grant("dma_only", 1'b0, 1'b1);

        // Tie round-robin: CPU, DMA, CPU, DMA
        for (int i = 0; i < 4; i++) begin
            next_cycle(); cpu_req = 1'b1; dma_req = 1'b1; #1;
            check_grant($sformatf("tie%0d", i), (i % 2) == 0, (i % 2) == 1);
        end

        // CPU store
        next_cycle(); dma_req = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'h1234_5678; #1;
        check_grant("st", 1'b1, 1'b0);
        check("st mem_we", {31'd0, mem_we}, 32'd1);
        check("st mem_a", mem_a, 32'h40);
        check("st mem_wd", mem_wd, 32'h1234_5678);

        // CPU load of the same address
        next_cycle(); cpu_we = 1'b0; #1;
        check("ld mem_we", {31'd0, mem_we}, 32'd0);
        check("ld cpu_rdata", cpu_rdata, 32'h1234_5678);

        // No requests: address mux defaults to the CPU port, no write
        next_cycle(); cpu_req = 1'b0; cpu_we = 1'b1; cpu_addr = 32'h44; cpu_wdata = 32'hCAFE_0001;
        dma_we = 1'b1; dma_addr = 32'h80; dma_wdata = 32'h0BAD_F00D; #1;
        check_grant("idle", 1'b0, 1'b0);
        check("idle mem_a", mem_a, 32'h44);
        check("idle mem_wd", mem_wd, 32'hCAFE_0001);
        check("idle mem_we", {31'd0, mem_we}, 32'd0);

        // Locked burst limit; last = CPU so the DMA wins the first tie
        burst_pat = 9'b1_1110_1111;
        for (int i = 0; i < 9; i++) begin
            next_cycle(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40;
            dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b0; dma_addr = 32'h40; #1;
            check_grant($sformatf("burst%0d", i), ~burst_pat[i], burst_pat[i]);
            if (burst_pat[i]) check($sformatf("burst%0d dma_rdata", i), dma_rdata, 32'h1234_5678);
            else check($sformatf("burst%0d cpu_rdata", i), cpu_rdata, 32'h1234_5678);
        end

        // CPU-only cycle to make last = CPU
        next_cycle(); dma_req = 1'b0; dma_lock = 1'b0; #1;
        check_grant("prep", 1'b1, 1'b0);

        // Early lock drop after 2 beats, then a fresh full-length burst
        drop_pat = 8'b0111_1011;
        for (int i = 0; i < 8; i++) begin
            next_cycle(); cpu_req = 1'b1; dma_req = 1'b1; dma_lock = (i != 2); #1;
            check_grant($sformatf("drop%0d", i), ~drop_pat[i], drop_pat[i]);
        end

        // Locked DMA write burst to 0x100 interrupted by reset after beat 2
        next_cycle(); cpu_req = 1'b0; dma_req = 1'b1; dma_lock = 1'b1; dma_we = 1'b1;
        dma_addr = 32'h100; dma_wdata = 32'hA5A5_A5A5; #1;
        check_grant("wb1", 1'b0, 1'b1);
        check("wb1 mem_we", {31'd0, mem_we}, 32'd1);
        check("wb1 mem_a", mem_a, 32'h100);
        next_cycle(); dma_addr = 32'h104; dma_wdata = 32'h5A5A_5A5A; #1;
        check_grant("wb2", 1'b0, 1'b1);
        next_cycle(); dma_addr = 32'h108; dma_wdata = 32'hFFFF_0000; cpu_req = 1'b1; reset = 1'b1; #1;
        check_grant("wb_rst", 1'b0, 1'b0);
        check("wb_rst mem_we", {31'd0, mem_we}, 32'd0);

        // After release the tie goes to the CPU first
        next_cycle(); reset = 1'b0; dma_lock = 1'b0; dma_we = 1'b0; cpu_addr = 32'h100; #1;
        check_grant("post_rst", 1'b1, 1'b0);
        check("post_rst rdata", cpu_rdata, 32'hA5A5_A5A5);
        next_cycle(); dma_req = 1'b0; cpu_addr = 32'h104; #1;
        check("beat2 rdata", cpu_rdata, 32'h5A5A_5A5A);
        next_cycle(); cpu_addr = 32'h108; #1;
        check("aborted rdata", cpu_rdata, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline's memory stage (CPU port) and a DMA/debug master (DMA port).
- Grants exactly one requester per cycle, using round-robin on conflict.
- Supports a DMA locked burst capped at MAX_BURST beats so the CPU cannot starve.
- Drives a stall to the hazard logic when the CPU access is not granted.

Parameters:
- MAX_BURST, default 4: maximum consecutive locked DMA beats before the lock is broken; legal range 1..15.
- CNT_W, default 4: width of the burst beat counter; must hold MAX_BURST.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU memory-stage access request (load or store).
- cpu_we  in  1  CPU store.
- cpu_addr  in  32  CPU byte address (aluoutM).
- cpu_wdata  in  32  CPU store data (writedataM).
- cpu_rdata  out  32  load data to the CPU; equals mem_rd.
- cpu_gnt  out  1  CPU access performed this cycle.
- cpu_stall  out  1  equals cpu_req & ~cpu_gnt; freezes F/D/E/M.
- dma_req  in  1  DMA access request.
- dma_we  in  1  DMA write.
- dma_addr  in  32  DMA byte address.
- dma_wdata  in  32  DMA write data.
- dma_lock  in  1  DMA requests a locked burst.
- dma_gnt  out  1  DMA access performed this cycle.
- dma_rdata  out  32  read data to the DMA; equals mem_rd.
- mem_we  out  1  data memory write enable.
- mem_a  out  32  data memory address.
- mem_wd  out  32  data memory write data.
- mem_rd  in  32  data memory combinational read data.

Behaviour:
- Memory timing is fixed: combinational read, write on the clock edge. The winner's access completes in its grant cycle, so a grant is a 0-cycle handshake.
- Grants are combinational from the requests and the registered state. Exactly one or zero grants per cycle; cpu_gnt & dma_gnt is never 1.
- Mux: mem_a and mem_wd come from the granted port. If there is no grant, mem_a=cpu_addr, mem_wd=cpu_wdata and mem_we=0.
- mem_we = (cpu_gnt & cpu_we) | (dma_gnt & dma_we).
- Registered state:
  - last: last granted port, 0=CPU, 1=DMA.
  - st: IDLE or LOCK.
  - cnt: CNT_W-bit locked beat count.
- Reset (asynchronous) sets last=1, st=IDLE, cnt=0. While reset is high, cpu_gnt=dma_gnt=mem_we=0 and cpu_stall=cpu_req.
- IDLE, single requester: that requester is granted.
- IDLE, both requesting: grant the port != last. Because last resets to 1, the CPU wins the first tie.
- IDLE to LOCK: on a dma_gnt with dma_lock=1, go to LOCK with cnt=1. If MAX_BURST=1, stay in IDLE with last=1.
- LOCK: the DMA has absolute priority while dma_req & dma_lock. Each DMA grant increments cnt.
  - When a grant makes cnt==MAX_BURST: go to IDLE, cnt=0, last=1. The CPU therefore wins the next conflict.
  - In LOCK with dma_req=0 or dma_lock=0: go to IDLE and cnt=0 in that cycle, and arbitrate as IDLE in that same cycle. The CPU is granted if requesting.
- last updates on every grant edge to the granted port; it holds when there is no grant.
- Reset asserted mid-burst aborts the lock immediately. The in-flight write does not happen because mem_we is forced to 0.
- cpu_stall never depends on cpu_stall or stall feedback, so there is no combinational loop.

Test Plan:
- Reset: hold reset with cpu_req=1. Expect cpu_gnt=0, cpu_stall=1, mem_we=0. After release, cpu_gnt=1 in the same cycle.
- Tie round-robin: cpu_req=dma_req=1 for 4 cycles, no lock. Expect grants CPU, DMA, CPU, DMA; cpu_stall=0,1,0,1.
- CPU store: cpu_we=1, cpu_addr=0x40, cpu_wdata=0x12345678, dma idle. Expect mem_we=1 and mem_a=0x40. A next-cycle CPU read of 0x40 returns cpu_rdata=0x12345678.
- Locked burst limit (MAX_BURST=4): DMA lock+req held, CPU requesting throughout. Expect dma_gnt for 4 cycles, then cpu_gnt for 1 cycle, then DMA re-locks for 4 more beats.
- Early lock drop: DMA locks for 2 beats, then dma_lock=0 while both requesting. Expect the CPU granted that cycle and st=IDLE.
- Reset mid-burst: assert reset after beat 2 of a locked DMA write burst to 0x100. Expect mem_we=0 immediately. After release, a tie grants the CPU first.
